gshare_bpred: RTL and testbench
===============================

# gshare_bpred

Parametrised direction predictor for the 5-stage RV32I core, the successor to the single-table bimodal predictor. It provides a combinational taken/not-taken prediction in F. The table index is either the PC alone (bimodal mode) or the PC XOR a global history register (gshare mode). Saturating counters of configurable width are updated when the branch resolves in D. The block also provides a sequential table-flush engine and saturating branch/mispredict statistics counters.

## Interface
- INDEX_SIZE, 10: log2 of table depth.
- CTR_WIDTH, 2: counter width, legal range 2..4.
- HIST_LEN, 8: GHR length, legal range 1..INDEX_SIZE.
- MODE, 1: 0 = bimodal (no history in index), 1 = gshare.
- PC_LSB, 2: PC bits dropped before indexing.
- STAT_WIDTH, 32: width of the statistics counters.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- pcF  in  32  fetch PC.
- BpredF  out  1  prediction: MSB of the indexed counter.
- idxF  out  INDEX_SIZE  index used for the prediction; carried down the pipeline with the instruction.
- idxD  in  INDEX_SIZE  idxF of the branch now in D.
- predD  in  1  BpredF of the branch now in D.
- BpredWriteD  in  1  a conditional branch has resolved in D this cycle.
- br_takenD  in  1  resolved direction.
- flush_req  in  1  single-cycle request to reinitialise the table.
- busy  out  1  flush in progress.
- stat_clr  in  1  synchronous clear of the statistics counters.
- br_count  out  STAT_WIDTH  resolved branches.
- mispred_count  out  STAT_WIDTH  mispredicted branches.

## Operation
- **Read index:** hf = pcF[PC_LSB+INDEX_SIZE-1:PC_LSB].
  - MODE=0: idxF = hf.
  - MODE=1: idxF = hf XOR the GHR zero-extended to INDEX_SIZE. The GHR occupies the low bits.
- **Prediction:** BpredF = table[idxF][CTR_WIDTH-1].
  - While busy=1, BpredF is forced to 0.
  - idxF is still driven while busy.
- **Update:** when BpredWriteD=1 and busy=0, table[idxD] changes at the clock edge.
  - br_takenD=1: increment, saturating at all-ones.
  - br_takenD=0: decrement, saturating at 0.
  - The update uses idxD, never a recomputed index, so a GHR change between F and D cannot misdirect it.
- **GHR:** when BpredWriteD=1 and busy=0, ghr <= {ghr[HIST_LEN-2:0], br_takenD}. When HIST_LEN=1, ghr <= br_takenD. The GHR is held in MODE=0 but has no effect on the index.
- **Statistics:** when BpredWriteD=1, br_count increments. If additionally predD != br_takenD, mispred_count increments.
  - The counters are updated even while busy.
  - Both saturate at all-ones.
  - stat_clr zeroes both. If stat_clr and an increment occur in the same cycle, stat_clr wins.
- **Flush FSM:** states IDLE and SWEEP, with pointer ptr of INDEX_SIZE bits.
  - IDLE with flush_req=1: at the edge, go to SWEEP, ptr <= 0, ghr <= 0.
  - SWEEP: each edge writes table[ptr] <= WEAK and increments ptr. When ptr reaches all-ones, that entry is written and the FSM returns to IDLE.
  - flush_req while in SWEEP is ignored.
  - WEAK = 1 followed by CTR_WIDTH-1 zeros (weakly taken, e.g. 2'b10).
- **Flush vs update:** if flush_req is accepted in the same cycle as BpredWriteD, the table and GHR updates are dropped. The statistics update still occurs.
- **Reset (asynchronous, active-high):**
  - all table entries = WEAK
  - ghr = 0
  - state = IDLE, ptr = 0, busy = 0
  - br_count = 0, mispred_count = 0
  - Reset asserted mid-SWEEP aborts the sweep immediately.

## Timing
- BpredF and idxF are combinational from pcF, the table, the GHR and the state; zero latency.
- A table update or GHR shift at edge N is visible to the F read from cycle N+1 onward.
- Same-cycle read/write of the same index returns the pre-update value; there is no bypass.
- busy is a registered output: high for exactly 2**INDEX_SIZE cycles, starting the cycle after flush_req is sampled.
- The statistics counters are registered and reflect events up to the previous edge.

## Test plan
- Reset with INDEX_SIZE=4, MODE=0.
  - Stimulus: sweep pcF over 16 word addresses.
  - Required: BpredF=1 everywhere; idxF = pcF[5:2]; br_count=0.
- Saturation, MODE=0, idxD=3.
  - Three not-taken updates: counter 2→1→0→0; BpredF for pcF=0xC becomes 0 after the first update.
  - Then four taken updates: counter 0→1→2→3→3.
- gshare with HIST_LEN=4.
  - Stimulus: resolve T,T,N,T.
  - Required: ghr=4'b1101; pcF=0x0 gives idxF=0xD; pcF=0x34 gives idxF=0xD XOR 0xD = 0x0.
- Flush with INDEX_SIZE=4.
  - Stimulus: pulse flush_req after training entry 5 to 0.
  - Required: busy=1 for 16 cycles; BpredF=0 throughout; ghr=0; entry 5 reads 2 (BpredF=1) afterwards.
  - A second flush_req at busy cycle 3 does not extend busy.
- Simultaneous events.
  - Stimulus: flush_req and BpredWriteD taken with predD=0 in the same cycle.
  - Required: table and GHR unchanged by the update; br_count+1 and mispred_count+1.
  - Stimulus: stat_clr together with BpredWriteD. Required: both counters become 0.
- Abort and saturation.
  - Stimulus: assert reset at busy cycle 7. Required: busy=0 immediately; all entries WEAK.
  - Stimulus: with STAT_WIDTH=4, 20 resolved branches. Required: br_count holds at 15.

Source files
------------

// File: rtl/gshare_bpred.sv
// gshare / bimodal direction predictor with saturating counters,
// a sequential table-flush engine and branch statistics counters.
module gshare_bpred #(
    parameter int INDEX_SIZE = 10,
    parameter int CTR_WIDTH  = 2,
    parameter int HIST_LEN   = 8,
    parameter int MODE       = 1,
    parameter int PC_LSB     = 2,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pcF,
    output logic                  BpredF,
    output logic [INDEX_SIZE-1:0] idxF,
    input  logic [INDEX_SIZE-1:0] idxD,
    input  logic                  predD,
    input  logic                  BpredWriteD,
    input  logic                  br_takenD,
    input  logic                  flush_req,
    output logic                  busy,
    input  logic                  stat_clr,
    output logic [STAT_WIDTH-1:0] br_count,
    output logic [STAT_WIDTH-1:0] mispred_count
);

    localparam int DEPTH = 1 << INDEX_SIZE;
    localparam logic [CTR_WIDTH-1:0]  WEAK     = {1'b1, {(CTR_WIDTH-1){1'b0}}};
    localparam logic [CTR_WIDTH-1:0]  CTR_ONE  = 1;
    localparam logic [INDEX_SIZE-1:0] PTR_ONE  = 1;
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = 1;

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [INDEX_SIZE-1:0] r_ptr;
    logic [HIST_LEN-1:0]   r_ghr;
    logic [HIST_LEN-1:0]   w_ghr_shift;
    logic [INDEX_SIZE-1:0] w_ghr_ext;
    logic [CTR_WIDTH-1:0]  r_table [DEPTH];
    logic [INDEX_SIZE-1:0] w_hf;
    logic [INDEX_SIZE-1:0] w_idx;
    logic [CTR_WIDTH-1:0]  w_cur;
    logic [CTR_WIDTH-1:0]  w_ctr_nxt;
    logic                  w_flush_acc;
    logic                  w_upd;
    logic [STAT_WIDTH-1:0] r_br_count;
    logic [STAT_WIDTH-1:0] r_mis_count;

    assign w_hf = pcF[PC_LSB+INDEX_SIZE-1:PC_LSB];

    if (PC_LSB > 0) begin : g_pc_lo
        logic w_unused_pc_lo;
        assign w_unused_pc_lo = ^pcF[PC_LSB-1:0];
    end
    if (PC_LSB + INDEX_SIZE < 32) begin : g_pc_hi
        logic w_unused_pc_hi;
        assign w_unused_pc_hi = ^pcF[31:PC_LSB+INDEX_SIZE];
    end

    if (HIST_LEN == INDEX_SIZE) begin : g_ext_full
        assign w_ghr_ext = r_ghr;
    end else begin : g_ext_pad
        assign w_ghr_ext = {{(INDEX_SIZE-HIST_LEN){1'b0}}, r_ghr};
    end

    if (HIST_LEN == 1) begin : g_sh1
        assign w_ghr_shift = br_takenD;
    end else begin : g_shn
        assign w_ghr_shift = {r_ghr[HIST_LEN-2:0], br_takenD};
    end

    if (MODE == 1) begin : g_gshare
        assign w_idx = w_hf ^ w_ghr_ext;
    end else begin : g_bimodal
        logic w_unused_ghr;
        assign w_idx        = w_hf;
        assign w_unused_ghr = ^w_ghr_ext;
    end

    assign busy        = (r_state == S_SWEEP);
    assign w_flush_acc = flush_req && (r_state == S_IDLE);
    assign w_upd       = BpredWriteD && !busy && !w_flush_acc;
    assign idxF        = w_idx;
    assign BpredF      = busy ? 1'b0 : r_table[w_idx][CTR_WIDTH-1];
    assign w_cur       = r_table[idxD];

    // Saturating increment/decrement of the resolving branch's counter
    always_comb begin
        w_ctr_nxt = w_cur;
        if (br_takenD) begin
            if (w_cur != '1) w_ctr_nxt = w_cur + CTR_ONE;
        end else begin
            if (w_cur != '0) w_ctr_nxt = w_cur - CTR_ONE;
        end
    end

    // Flush FSM next state: sweep ends after the all-ones entry
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (flush_req) w_state_nxt = S_SWEEP;
            S_SWEEP: if (r_ptr == '1) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Flush FSM state and sweep pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_flush_acc)
                r_ptr <= '0;
            else if (r_state == S_SWEEP)
                r_ptr <= r_ptr + PTR_ONE;
        end
    end

    // Counter table: sweep rewrites WEAK, otherwise resolved-branch update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_table[i] <= WEAK;
        end else if (r_state == S_SWEEP) begin
            r_table[r_ptr] <= WEAK;
        end else if (w_upd) begin
            r_table[idxD] <= w_ctr_nxt;
        end
    end

    // Global history: cleared on flush accept, shifted on resolution
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ghr <= '0;
        else if (w_flush_acc)
            r_ghr <= '0;
        else if (w_upd)
            r_ghr <= w_ghr_shift;
    end

    // Saturating statistics; clear has priority and busy does not gate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_br_count  <= '0;
            r_mis_count <= '0;
        end else if (stat_clr) begin
            r_br_count  <= '0;
            r_mis_count <= '0;
        end else if (BpredWriteD) begin
            if (r_br_count != '1) r_br_count <= r_br_count + STAT_ONE;
            if (predD != br_takenD && r_mis_count != '1)
                r_mis_count <= r_mis_count + STAT_ONE;
        end
    end

    assign br_count      = r_br_count;
    assign mispred_count = r_mis_count;

endmodule

// File: tb/tb_gshare_bpred.sv
// Directed bench: a bimodal and a gshare instance share one stimulus
// stream; expected values are hand-derived counter/GHR states.
module tb_gshare_bpred;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [31:0] pcF = '0;
    logic [3:0] idxD = '0;
    logic       predD = 1'b0;
    logic       BpredWriteD = 1'b0;
    logic       br_takenD = 1'b0;
    logic       flush_req = 1'b0;
    logic       stat_clr = 1'b0;

    logic       bp_b, bp_g, busy_b, busy_g;
    logic [3:0] idx_b, idx_g;
    logic [3:0] brc_b, mis_b, brc_g, mis_g;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gshare_bpred #(.INDEX_SIZE(4), .CTR_WIDTH(2), .HIST_LEN(4),
                   .MODE(0), .PC_LSB(2), .STAT_WIDTH(4)) u_bim (
        .clk(clk), .reset(reset), .pcF(pcF), .BpredF(bp_b), .idxF(idx_b),
        .idxD(idxD), .predD(predD), .BpredWriteD(BpredWriteD),
        .br_takenD(br_takenD), .flush_req(flush_req), .busy(busy_b),
        .stat_clr(stat_clr), .br_count(brc_b), .mispred_count(mis_b));

    gshare_bpred #(.INDEX_SIZE(4), .CTR_WIDTH(2), .HIST_LEN(4),
                   .MODE(1), .PC_LSB(2), .STAT_WIDTH(4)) u_gsh (
        .clk(clk), .reset(reset), .pcF(pcF), .BpredF(bp_g), .idxF(idx_g),
        .idxD(idxD), .predD(predD), .BpredWriteD(BpredWriteD),
        .br_takenD(br_takenD), .flush_req(flush_req), .busy(busy_g),
        .stat_clr(stat_clr), .br_count(brc_g), .mispred_count(mis_g));

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [3:0] idx, input logic t, input logic p);
        idxD = idx;
        br_takenD = t;
        predD = p;
        BpredWriteD = 1'b1;
        tick();
        BpredWriteD = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    logic exp_bp [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    logic tk [9]     = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
    logic tg [4]     = '{1, 1, 0, 1};

    initial begin
        int n, bad;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // reset state over all 16 entries
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            pcF = 32'(i * 4);
            #1;
            if (bp_b !== 1'b1 || idx_b !== 4'(i) || idx_g !== 4'(i)) bad++;
        end
        chk("rst_table", 32'(bad), 0);
        chk("rst_busy", {31'b0, busy_b}, 0);
        chk("rst_brc", {28'b0, brc_b}, 0);
        chk("rst_mis", {28'b0, mis_b}, 0);

        // saturation at entry 3: N,N,N,T,T,T,T,N,N
        pcF = 32'hC;
        for (int i = 0; i < 9; i++) begin
            upd(4'd3, tk[i], 1'b1);
            chk($sformatf("sat_%0d", i), {31'b0, bp_b}, {31'b0, exp_bp[i]});
        end
        chk("sat_brc", {28'b0, brc_b}, 9);
        chk("sat_mis", {28'b0, mis_b}, 5);

        // no bypass: read same entry during its update cycle
        idxD = 4'd3; br_takenD = 1'b1; BpredWriteD = 1'b1;
        #1;
        chk("no_bypass", {31'b0, bp_b}, 0);
        tick();
        BpredWriteD = 1'b0;

        // gshare history T,T,N,T -> ghr 4'b1101
        do_reset();
        pcF = 32'h0;
        for (int i = 0; i < 4; i++) begin
            upd(4'd0, tg[i], 1'b0);
            if (i == 0) chk("ghr_first", {28'b0, idx_g}, 1);
        end
        chk("ghr_idx0", {28'b0, idx_g}, 32'hD);
        pcF = 32'h34;
        #1;
        chk("ghr_idx34", {28'b0, idx_g}, 0);
        chk("bim_idx34", {28'b0, idx_b}, 32'hD);

        // flush: train entry 5 to 0, set ghr to 0001
        do_reset();
        upd(4'd5, 1'b0, 1'b1);
        upd(4'd5, 1'b0, 1'b1);
        upd(4'd9, 1'b1, 1'b1);
        pcF = 32'h14;
        #1;
        chk("trained5", {31'b0, bp_b}, 0);
        pcF = 32'h0;
        #1;
        chk("pre_ghr", {28'b0, idx_g}, 1);
        pcF = 32'h14;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        n = 0;
        bad = 0;
        while (busy_b && n < 40) begin
            n++;
            if (bp_b) bad++;
            flush_req = (n == 3);
            tick();
        end
        flush_req = 1'b0;
        chk("busy_len", 32'(n), 16);
        chk("busy_bpred0", 32'(bad), 0);
        #1;
        chk("post_e5", {31'b0, bp_b}, 1);
        pcF = 32'h0;
        #1;
        chk("post_ghr", {28'b0, idx_g}, 0);

        // flush + taken mispredicted update in the same cycle
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("clr_brc", {28'b0, brc_b}, 0);
        flush_req = 1'b1;
        upd(4'd0, 1'b1, 1'b0);
        flush_req = 1'b0;
        chk("sim_busy", {31'b0, busy_b}, 1);
        chk("sim_brc", {28'b0, brc_b}, 1);
        chk("sim_mis", {28'b0, mis_b}, 1);
        n = 0;
        while (busy_b && n < 40) begin
            n++;
            tick();
        end
        chk("sim_done", 32'(n), 16);
        pcF = 32'h0;
        #1;
        chk("sim_ghr", {28'b0, idx_g}, 0);
        chk("sim_e0", {31'b0, bp_b}, 1);

        // stat_clr wins over an increment
        stat_clr = 1'b1;
        upd(4'd1, 1'b1, 1'b0);
        stat_clr = 1'b0;
        chk("clrw_brc", {28'b0, brc_b}, 0);
        chk("clrw_mis", {28'b0, mis_b}, 0);

        // abort a sweep with reset at busy cycle 7
        upd(4'd2, 1'b0, 1'b1);
        upd(4'd2, 1'b0, 1'b1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int i = 1; i < 7; i++) tick();
        chk("abort_pre", {31'b0, busy_b}, 1);
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy_b}, 0);
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            pcF = 32'(i * 4);
            #1;
            if (bp_b !== 1'b1) bad++;
        end
        chk("abort_weak", 32'(bad), 0);

        // statistics saturate at 15
        for (int i = 0; i < 20; i++) upd(4'd7, 1'b1, 1'b0);
        chk("stat_sat_brc", {28'b0, brc_b}, 15);
        chk("stat_sat_mis", {28'b0, mis_b}, 15);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
